// File: rtl/mio_bus_responder.sv
// Memory/IO slave for the CPU data bus: RAM, GPIO register and cycle counter behind a wait-state FSM.
// Optional macro MIO_ACCESS_COUNT_EN builds a completed-transaction counter on access_count.
module mio_bus_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int GPIO_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              MIO_ready,
  output logic              err,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [31:0]       access_count
);

  // Handshake: req/we/addr/wdata are sampled only on an edge where the FSM is IDLE;
  // completion is a single-cycle MIO_ready with rdata/err valid in that same cycle.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e              state_q;
  logic [3:0]          wait_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                ready_q;
  logic                err_q;
  logic [GPIO_W-1:0]   gpio_q;
  logic [31:0]         cyc_q;
  logic [31:0]         mem [2**ADDR_W];

  logic                t_we;
  logic [31:0]         t_addr;
  logic [31:0]         t_wdata;
  logic                enter_done;
  logic [ADDR_W-1:0]   ram_idx;
  logic                sel_ram;
  logic                sel_gpio;
  logic                sel_cyc;
  logic [31:0]         rdata_d;
  logic                err_d;
  logic                unused_addr;

  // With zero wait states the request completes on its acceptance edge, so decode the live bus in IDLE.
  always_comb begin
    t_we       = we_q;
    t_addr     = addr_q;
    t_wdata    = wdata_q;
    enter_done = 1'b0;
    if (state_q == S_IDLE) begin
      t_we       = we;
      t_addr     = addr;
      t_wdata    = wdata;
      enter_done = req && (WAIT_CYCLES == 0);
    end else if (state_q == S_WAIT) begin
      enter_done = (wait_q == 4'd1);
    end
  end

  assign ram_idx     = t_addr[ADDR_W+1:2];
  assign sel_ram     = (t_addr[31:28] == 4'h0);
  assign sel_gpio    = (t_addr[31:28] == 4'hE);
  assign sel_cyc     = (t_addr[31:28] == 4'hF);
  assign unused_addr = ^{t_addr[27:ADDR_W+2], t_addr[1:0]};

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    unique case (t_addr[31:28])
      4'h0:    rdata_d = t_we ? 32'd0 : mem[ram_idx];
      4'hE:    rdata_d = t_we ? 32'd0 : 32'(gpio_in);
      4'hF:    rdata_d = t_we ? 32'd0 : cyc_q;
      default: err_d   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      gpio_q  <= '0;
      cyc_q   <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= cyc_q + 32'd1;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            wait_q  <= WAIT_INIT;
            state_q <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_q <= wait_q - 4'd1;
          if (wait_q == 4'd1) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (enter_done) begin
        ready_q <= 1'b1;
        err_q   <= err_d;
        rdata_q <= rdata_d;
        if (t_we && sel_gpio) gpio_q <= t_wdata[GPIO_W-1:0];
        // A counter load overrides this cycle's increment.
        if (t_we && sel_cyc)  cyc_q  <= t_wdata;
      end
    end
  end

  // RAM has no reset; the rst term keeps a zero-wait request from committing while reset is held.
  always_ff @(posedge clk) begin
    if (enter_done && !rst && t_we && sel_ram) mem[ram_idx] <= t_wdata;
  end

`ifdef MIO_ACCESS_COUNT_EN
  logic [31:0] acc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             acc_q <= 32'd0;
    else if (enter_done) acc_q <= acc_q + 32'd1;
  end
  assign access_count = acc_q;
`else
  assign access_count = 32'd0;
`endif

  assign rdata     = rdata_q;
  assign MIO_ready = ready_q;
  assign err       = err_q;
  assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: directed scenarios plus random traffic against a region-level model.
module tb_mio_bus_responder;
  localparam int ADDR_W = 10;
  localparam int GPIO_W = 16;
  localparam int WAIT_A = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT A (two wait states) ----------------
  logic              req = 1'b0, we = 1'b0;
  logic [31:0]       addr = '0, wdata = '0;
  logic [31:0]       rdata, access_count;
  logic              MIO_ready, err;
  logic [GPIO_W-1:0] gpio_in = '0, gpio_out;

  mio_bus_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_A), .GPIO_W(GPIO_W)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .MIO_ready(MIO_ready), .err(err),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .access_count(access_count)
  );

  // ---------------- DUT B (zero wait states) ----------------
  logic              b_req = 1'b0, b_we = 1'b0;
  logic [31:0]       b_addr = '0, b_wdata = '0;
  logic [31:0]       b_rdata, b_access_count;
  logic              b_ready, b_err;
  logic [GPIO_W-1:0] b_gpio_in = '0, b_gpio_out;

  mio_bus_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0), .GPIO_W(GPIO_W)) u_dut0 (
    .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .rdata(b_rdata), .MIO_ready(b_ready), .err(b_err),
    .gpio_in(b_gpio_in), .gpio_out(b_gpio_out), .access_count(b_access_count)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]       exp_q[$];
  logic [31:0]       ram_m [int];
  int                written_idx[$];
  logic [GPIO_W-1:0] gpio_m = '0;
  logic [31:0]       cyc_base = '0;
  int unsigned       cyc_edge = 0;
  bit                cyc_known = 1'b0;
  int unsigned       acc_m = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_access_count();
`ifdef MIO_ACCESS_COUNT_EN
    return 32'(acc_m);
`else
    return 32'd0;
`endif
  endfunction

  // Called at a negedge with DUT A idle; returns at a negedge with DUT A idle again.
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d);
    int          lat;
    int unsigned done_edge;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          idx;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    // Inputs are don't-care once accepted.
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    lat = 0;
    while (!MIO_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    // Ready in cycle T+1+WAIT: seen after WAIT further edges past the acceptance edge.
    check_eq("latency", 32'(lat), 32'(WAIT_A));
    done_edge = edge_n;
    exp_rd = 32'd0;
    exp_err = 1'b0;
    case (a[31:28])
      4'h0: begin
        idx = int'((a >> 2) & ((32'd1 << ADDR_W) - 1));
        if (w) begin
          if (!ram_m.exists(idx)) written_idx.push_back(idx);
          ram_m[idx] = d;
        end else exp_rd = ram_m[idx];
      end
      4'hE: if (w) gpio_m = d[GPIO_W-1:0]; else exp_rd = 32'(gpio_in);
      4'hF: begin
        if (w) begin
          cyc_base = d; cyc_edge = done_edge; cyc_known = 1'b1;
        end else exp_rd = cyc_base + 32'(done_edge - cyc_edge - 1);
      end
      default: exp_err = 1'b1;
    endcase
    acc_m++;
    exp_q.push_back(exp_rd);
    if (!w || exp_err) check_eq("rdata", rdata, exp_q.pop_front());
    else void'(exp_q.pop_front());
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("gpio_out", 32'(gpio_out), 32'(gpio_m));
    check_eq("access_count", access_count, exp_access_count());
    @(negedge clk);
    check_eq("ready_width", 32'(MIO_ready), 32'd0);
  endtask

  task automatic model_reset();
    gpio_m = '0;
    acc_m = 0;
    cyc_known = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] b_vals [4];
  logic [31:0] b_adr  [4];
  logic [31:0] a_tmp;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_ready", 32'(MIO_ready), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_gpio", 32'(gpio_out), 32'd0);
    check_eq("rst_acc", access_count, 32'd0);

    // Zero-wait DUT: req held high, four writes then four reads, one completion every 2 cycles.
    for (int i = 0; i < 4; i++) begin
      b_adr[i]  = {4'h0, 28'($urandom)};
      b_adr[i][ADDR_W+1:2] = ADDR_W'(i * 5 + 1);
      b_vals[i] = $urandom;
    end
    begin
      int unsigned prev_edge;
      int n;
      prev_edge = 0;
      b_req = 1'b1; b_we = 1'b1; b_addr = b_adr[0]; b_wdata = b_vals[0];
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        n = 0;
        while (!b_ready && n < 10) begin
          @(negedge clk);
          n++;
        end
        check_eq("b2b_ready", 32'(b_ready), 32'd1);
        check_eq("b2b_err", 32'(b_err), 32'd0);
        if (i > 0) check_eq("b2b_period", 32'(edge_n - prev_edge), 32'd2);
        if (i >= 4) check_eq("b2b_rdata", b_rdata, b_vals[i-4]);
        prev_edge = edge_n;
        if (i < 7) begin
          b_we = (i + 1 < 4);
          b_addr = b_adr[(i + 1) % 4];
          b_wdata = (i + 1 < 4) ? b_vals[i + 1] : $urandom;
        end
      end
      b_req = 1'b0;
    end

    // RAM write then read-back.
    access(1'b1, 32'h0000_0010, 32'h1234_5678);
    access(1'b0, 32'h0000_0010, 32'h0);
    check_eq("ram_readback", rdata, 32'h1234_5678);

    // GPIO.
    gpio_in = 16'h3C3C;
    access(1'b1, 32'hE000_0000, 32'h0000_A5A5);
    access(1'b0, 32'hE000_0000, 32'h0);
    check_eq("gpio_read", rdata, 32'h0000_3C3C);
    check_eq("gpio_out_val", 32'(gpio_out), 32'h0000_A5A5);

    // Counter load near the top, then read after it wraps.
    access(1'b1, 32'hF000_0000, 32'hFFFF_FFFE);
    repeat (3) @(negedge clk);
    access(1'b0, 32'hF000_0000, 32'h0);
    check_eq("cnt_wrapped_small", 32'(rdata < 32'd16), 32'd1);

    // Unmapped region: error, zero data, no side effects.
    access(1'b1, 32'h8000_0000, 32'hDEAD_BEEF);
    access(1'b0, 32'h8000_0000, 32'h0);
    access(1'b0, 32'h0000_0010, 32'h0);

    // Reset in the middle of a write's wait states.
    access(1'b1, 32'h0000_0020, 32'h1111_1111);
    req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h2222_2222;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    model_reset();
    begin
      int pulses;
      pulses = 0;
      repeat (2) begin
        @(negedge clk);
        if (MIO_ready) pulses++;
      end
      rst = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (MIO_ready) pulses++;
      end
      check_eq("abort_no_ready", 32'(pulses), 32'd0);
    end
    check_eq("abort_acc", access_count, exp_access_count());
    check_eq("abort_gpio", 32'(gpio_out), 32'd0);
    access(1'b0, 32'h0000_0020, 32'h0);
    check_eq("abort_old_data", rdata, 32'h1111_1111);

    // Random traffic.
    for (int t = 0; t < 80; t++) begin
      int kind;
      gpio_in = GPIO_W'($urandom);
      kind = $urandom_range(0, 5);
      a_tmp = $urandom;
      case (kind)
        0, 1: begin
          a_tmp[31:28] = 4'h0;
          access(1'b1, a_tmp, $urandom);
        end
        2: begin
          a_tmp[31:28] = 4'h0;
          a_tmp[ADDR_W+1:2] = ADDR_W'(written_idx[$urandom_range(0, written_idx.size() - 1)]);
          access(1'b0, a_tmp, $urandom);
        end
        3: begin
          a_tmp[31:28] = 4'hE;
          access(1'($urandom), a_tmp, $urandom);
        end
        4: begin
          a_tmp[31:28] = 4'hF;
          access(!cyc_known || 1'($urandom), a_tmp, $urandom);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        default: begin
          a_tmp[31:28] = 4'($urandom_range(1, 13));
          access(1'($urandom), a_tmp, $urandom);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
